// File: rtl/vec_mem_seq_if.sv
// Bus bundle between the vector memory sequencer, its controller,
// the 8-bit data memory port and the VRF write port.
interface vec_mem_seq_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LANE_W = 8
);
  logic                  start_load;
  logic                  start_store;
  logic [ADDR_W-1:0]     base_addr;
  logic [4*LANE_W-1:0]   vdata_in;
  logic [LANE_W-1:0]     mem_q;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [LANE_W-1:0]     mem_data;
  logic [4*LANE_W-1:0]   vdata_out;
  logic                  vrf_write;
  logic                  busy;
  logic                  done;

  // Controller / memory / VRF side.
  modport master (
    output start_load, start_store, base_addr, vdata_in, mem_q,
    input  mem_addr, mem_rd, mem_wr, mem_data, vdata_out, vrf_write, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start_load, start_store, base_addr, vdata_in, mem_q,
    output mem_addr, mem_rd, mem_wr, mem_data, vdata_out, vrf_write, busy, done
  );
endinterface

// File: rtl/vec_mem_seq.sv
// Vector memory sequencer: runs a vector load or store as a byte-serial
// burst of four accesses. Loads assemble a 4-lane vector for the VRF,
// stores serialise a latched vector out to memory. Lane 0 is the MS lane.
module vec_mem_seq #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LANE_W = 8
) (
  input  logic          clock,
  input  logic          reset,
  vec_mem_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LCAP,
    LWB,
    STORE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [ADDR_W-1:0]   base_q;
  logic [4*LANE_W-1:0] svec_q;
  logic [4*LANE_W-1:0] vdata_q, vdata_d;

  logic                accept;
  logic                load_go;
  logic                store_go;
  logic                cap_en;
  logic [1:0]          cap_lane;
  logic [1:0]          cap_slot;
  logic [1:0]          st_slot;

  // Start acceptance: LWB already frees the sequencer so a new
  // operation can follow the write-back without a lost cycle.
  always_comb begin
    accept   = (state_q == IDLE) || (state_q == LWB);
    load_go  = accept && bus.start_load;
    store_go = accept && !bus.start_load && bus.start_store;
  end

  // Next-state, lane index and memory/VRF strobes.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    bus.mem_addr  = base_q;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_data  = '0;
    bus.vrf_write = 1'b0;
    bus.done      = 1'b0;
    st_slot       = ~idx_q;
    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      LOAD: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = base_q + ADDR_W'(idx_q);
        idx_d        = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = LCAP;
      end
      LCAP: begin
        state_d = LWB;
      end
      LWB: begin
        bus.vrf_write = 1'b1;
        bus.done      = 1'b1;
        state_d       = IDLE;
      end
      STORE: begin
        bus.mem_wr   = 1'b1;
        bus.mem_addr = base_q + ADDR_W'(idx_q);
        bus.mem_data = svec_q[st_slot*LANE_W +: LANE_W];
        idx_d        = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          bus.done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load_go) begin
      state_d = LOAD;
      idx_d   = '0;
    end else if (store_go) begin
      state_d = STORE;
      idx_d   = '0;
    end
  end

  // Load data capture: memory read data trails the address by one cycle,
  // so the lane captured is one behind the lane being addressed.
  always_comb begin
    vdata_d  = vdata_q;
    cap_en   = ((state_q == LOAD) && (idx_q != 2'd0)) || (state_q == LCAP);
    cap_lane = (state_q == LCAP) ? 2'd3 : (idx_q - 2'd1);
    cap_slot = ~cap_lane;
    if (cap_en) vdata_d[cap_slot*LANE_W +: LANE_W] = bus.mem_q;
  end

  // Status outputs.
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.vdata_out = vdata_q;
  end

  // State, index, latched operands and assembled load vector.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      svec_q  <= '0;
      vdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vdata_q <= vdata_d;
      if (load_go || store_go) base_q <= bus.base_addr;
      if (store_go) svec_q <= bus.vdata_in;
    end
  end

endmodule

// File: tb/tb_vec_mem_seq.sv
// Bench for vec_mem_seq: a byte memory model, a scoreboard of expected
// memory writes and VRF write-backs, a store/load table and hand-written
// multi-cycle sequences.
module tb_vec_mem_seq;

  logic clock;
  logic reset;

  vec_mem_seq_if #(.ADDR_W(8), .LANE_W(8)) bus ();

  vec_mem_seq #(.ADDR_W(8), .LANE_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] vq[$];

  logic [7:0] mem [256];
  logic       pre_en = 1'b0;
  logic [7:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  // Registered-read byte memory with a preload port for the bench.
  always @(posedge clock) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_data;
    bus.mem_q <= mem[bus.mem_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every write / write-back must match the next expectation.
  always @(negedge clock) begin
    if (!reset) begin
      chk("rd_wr_exclusive", {63'd0, bus.mem_rd & bus.mem_wr}, 64'd0);
      if (bus.mem_wr) begin
        if (wq.size() == 0) chk("unexpected_write", {56'd0, bus.mem_addr}, 64'hFFFF);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", {56'd0, bus.mem_addr}, {56'd0, w.addr});
          chk("wr_data", {56'd0, bus.mem_data}, {56'd0, w.data});
        end
      end
      if (bus.vrf_write) begin
        if (vq.size() == 0) chk("unexpected_vrf_write", {32'd0, bus.vdata_out}, 64'hFFFF_FFFF_FFFF);
        else begin
          logic [31:0] v;
          v = vq.pop_front();
          chk("vrf_data", {32'd0, bus.vdata_out}, {32'd0, v});
        end
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clock); #1;
    pre_en = 1'b0;
  endtask

  // Returns 1 ns into cycle 1 of the operation.
  task automatic start_op(input bit ld, input bit st, input logic [7:0] b, input logic [31:0] v);
    @(posedge clock); #1;
    bus.start_load = ld; bus.start_store = st; bus.base_addr = b; bus.vdata_in = v;
    @(posedge clock); #1;
    bus.start_load = 1'b0; bus.start_store = 1'b0;
  endtask

  task automatic push_store(input logic [7:0] b, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      wr_t w;
      w.addr = b + 8'(i);
      w.data = v[31-8*i -: 8];
      wq.push_back(w);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (!bus.busy) begin ok = 1'b1; break; end
    end
    chk({nm, "_timeout"}, {63'd0, ok}, 64'd1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_addr"}, {56'd0, bus.mem_addr}, 64'd0);
    chk({nm, "_data"}, {56'd0, bus.mem_data}, 64'd0);
    chk({nm, "_vdata"}, {32'd0, bus.vdata_out}, 64'd0);
    chk({nm, "_strobes"}, {59'd0, bus.mem_rd, bus.mem_wr, bus.vrf_write, bus.busy, bus.done}, 64'd0);
  endtask

  typedef struct {
    logic [7:0]  base;
    logic [31:0] vec;
    logic [31:0] exp_load;
  } vec_t;

  initial begin
    vec_t tbl[5];
    logic [31:0] last_load;
    tbl[0] = '{base: 8'hFE, vec: 32'h01020304, exp_load: 32'h01020304};
    tbl[1] = '{base: 8'h00, vec: 32'hDEADBEEF, exp_load: 32'hDEADBEEF};
    tbl[2] = '{base: 8'h7D, vec: 32'h89ABCDEF, exp_load: 32'h89ABCDEF};
    tbl[3] = '{base: 8'hFF, vec: 32'h5A5AA5A5, exp_load: 32'h5A5AA5A5};
    tbl[4] = '{base: 8'hC0, vec: 32'h00FF7E81, exp_load: 32'h00FF7E81};

    reset = 1'b1;
    bus.start_load = 1'b0; bus.start_store = 1'b0;
    bus.base_addr = '0; bus.vdata_in = '0;
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);
    chk_all_zero("post_reset");

    // Cycle-exact load from 05.
    poke(8'h05, 8'h10); poke(8'h06, 8'h20); poke(8'h07, 8'h30); poke(8'h08, 8'h40);
    vq.push_back(32'h10203040);
    start_op(1'b1, 1'b0, 8'h05, 32'h0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      chk($sformatf("ld_c%0d_rd", c), {63'd0, bus.mem_rd}, {63'd0, (c <= 4)});
      chk($sformatf("ld_c%0d_addr", c), {56'd0, bus.mem_addr}, (c <= 4) ? 64'(5 + c - 1) : 64'h05);
      chk($sformatf("ld_c%0d_busy", c), {63'd0, bus.busy}, {63'd0, (c <= 6)});
      chk($sformatf("ld_c%0d_vrf_done", c), {62'd0, bus.vrf_write, bus.done}, (c == 6) ? 64'd3 : 64'd0);
      chk($sformatf("ld_c%0d_wr", c), {63'd0, bus.mem_wr}, 64'd0);
    end
    chk("ld_hold_vdata", {32'd0, bus.vdata_out}, 64'h10203040);

    // Cycle-exact store to 20.
    push_store(8'h20, 32'hA1B2C3D4);
    start_op(1'b0, 1'b1, 8'h20, 32'hA1B2C3D4);
    bus.vdata_in = 32'h0; bus.base_addr = 8'h99;
    for (int c = 1; c <= 5; c++) begin
      logic [31:0] sv;
      sv = 32'hA1B2C3D4;
      @(negedge clock);
      chk($sformatf("st_c%0d_wr", c), {63'd0, bus.mem_wr}, {63'd0, (c <= 4)});
      chk($sformatf("st_c%0d_addr", c), {56'd0, bus.mem_addr}, (c <= 4) ? 64'(8'h20 + c - 1) : 64'h20);
      chk($sformatf("st_c%0d_data", c), {56'd0, bus.mem_data}, (c <= 4) ? {56'd0, sv[31-8*(c-1) -: 8]} : 64'd0);
      chk($sformatf("st_c%0d_done", c), {63'd0, bus.done}, {63'd0, (c == 4)});
      chk($sformatf("st_c%0d_busy", c), {63'd0, bus.busy}, {63'd0, (c <= 4)});
      chk($sformatf("st_c%0d_vrf", c), {63'd0, bus.vrf_write}, 64'd0);
    end
    chk("st_keeps_vdata", {32'd0, bus.vdata_out}, 64'h10203040);

    // Table: store each vector then load it back (wrap cases included).
    last_load = 32'h10203040;
    for (int i = 0; i < 5; i++) begin
      push_store(tbl[i].base, tbl[i].vec);
      start_op(1'b0, 1'b1, tbl[i].base, tbl[i].vec);
      wait_idle($sformatf("tbl%0d_st", i));
      chk($sformatf("tbl%0d_st_vdata_kept", i), {32'd0, bus.vdata_out}, {32'd0, last_load});
      vq.push_back(tbl[i].exp_load);
      start_op(1'b1, 1'b0, tbl[i].base, 32'h0);
      wait_idle($sformatf("tbl%0d_ld", i));
      chk($sformatf("tbl%0d_ld_vdata", i), {32'd0, bus.vdata_out}, {32'd0, tbl[i].exp_load});
      last_load = tbl[i].exp_load;
    end

    // Simultaneous starts: load wins, no writes.
    poke(8'h30, 8'h11); poke(8'h31, 8'h22); poke(8'h32, 8'h33); poke(8'h33, 8'h44);
    vq.push_back(32'h11223344);
    start_op(1'b1, 1'b1, 8'h30, 32'hFFFFFFFF);
    wait_idle("both");
    chk("both_vdata", {32'd0, bus.vdata_out}, 64'h11223344);

    // Store pulsed during load cycle 3 is ignored.
    vq.push_back(32'h11223344);
    start_op(1'b1, 1'b0, 8'h30, 32'h0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    bus.start_store = 1'b1; bus.vdata_in = 32'hBADBAD00; bus.base_addr = 8'h50;
    @(posedge clock); #1;
    bus.start_store = 1'b0;
    repeat (4) @(negedge clock);
    chk("ign_idle_c7", {62'd0, bus.busy, bus.mem_wr}, 64'd0);
    repeat (2) @(negedge clock);
    chk("ign_still_idle", {62'd0, bus.busy, bus.mem_wr}, 64'd0);

    // Reset in store cycle 2.
    poke(8'h21, 8'h55); poke(8'h22, 8'h55); poke(8'h23, 8'h55);
    wq.push_back('{addr: 8'h20, data: 8'hA1});
    start_op(1'b0, 1'b1, 8'h20, 32'hA1B2C3D4);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("midrst_no_wr21", {56'd0, mem[8'h21]}, 64'h55);
    chk("midrst_no_wr23", {56'd0, mem[8'h23]}, 64'h55);
    chk("midrst_wq_empty", 64'(wq.size()), 64'd0);
    vq.push_back(32'hA1555555);
    start_op(1'b1, 1'b0, 8'h20, 32'h0);
    wait_idle("midrst_ld");
    chk("midrst_ld_vdata", {32'd0, bus.vdata_out}, 64'hA1555555);

    // Back-to-back: store accepted at the edge ending load cycle 6.
    vq.push_back(32'h10203040);
    push_store(8'h40, 32'hCAFEF00D);
    start_op(1'b1, 1'b0, 8'h05, 32'h0);
    repeat (5) begin @(posedge clock); #1; end
    bus.start_store = 1'b1; bus.base_addr = 8'h40; bus.vdata_in = 32'hCAFEF00D;
    @(posedge clock); #1;
    bus.start_store = 1'b0;
    @(negedge clock);
    chk("b2b_wr", {63'd0, bus.mem_wr}, 64'd1);
    chk("b2b_addr", {56'd0, bus.mem_addr}, 64'h40);
    chk("b2b_busy", {63'd0, bus.busy}, 64'd1);
    wait_idle("b2b");
    chk("b2b_vdata_kept", {32'd0, bus.vdata_out}, 64'h10203040);

    repeat (2) @(negedge clock);
    chk("final_wq_empty", 64'(wq.size()), 64'd0);
    chk("final_vq_empty", 64'(vq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
